// File: rtl/legv8_pkg.sv
// Shared defaults and FSM encoding for the LEGv8 register file.
package legv8_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int XZR_IDX            = (1 << DEFAULT_ADDR_WIDTH) - 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } regfile_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// One pending bit per register: flush clears a single swept entry, set marks an
// in-flight producer, clear retires it; set beats clear on the same entry.
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  i_flush,
    input  logic [ADDR_WIDTH-1:0] i_flush_idx,
    input  logic                  i_set,
    input  logic [ADDR_WIDTH-1:0] i_set_idx,
    input  logic                  i_clr,
    input  logic [ADDR_WIDTH-1:0] i_clr_idx,
    input  logic [ADDR_WIDTH-1:0] i_lookup_idx_1,
    input  logic [ADDR_WIDTH-1:0] i_lookup_idx_2,
    output logic                  o_pending_1,
    output logic                  o_pending_2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0] r_pending;

    // The later non-blocking assignment wins, which gives set priority over clear.
    always_ff @(posedge clk) begin
        if (i_flush) begin
            r_pending[i_flush_idx] <= 1'b0;
        end else begin
            if (i_clr) begin
                r_pending[i_clr_idx] <= 1'b0;
            end
            if (i_set) begin
                r_pending[i_set_idx] <= 1'b1;
            end
        end
    end

    assign o_pending_1 = r_pending[i_lookup_idx_1];
    assign o_pending_2 = r_pending[i_lookup_idx_2];

endmodule

// File: rtl/legv8_param_regfile.sv
// Parameterised LEGv8 register file: two combinational read ports with write-through,
// one write port, pending-bit scoreboard and a post-reset clearing sweep.
module legv8_param_regfile
    import legv8_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg_address_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_address_2,
    input  logic [ADDR_WIDTH-1:0] write_reg_address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  reg_write,
    input  logic                  reserve_valid,
    input  logic [ADDR_WIDTH-1:0] reserve_address,
    input  logic                  clear_req,
    output logic [DATA_WIDTH-1:0] reg_out_1,
    output logic [DATA_WIDTH-1:0] reg_out_2,
    output logic                  busy_1,
    output logic                  busy_2,
    output logic                  ready,
    output regfile_state_t        o_dbg_state
);

    localparam int                    DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] XZR   = ADDR_WIDTH'(DEPTH - 1);

    regfile_state_t        r_state;
    regfile_state_t        w_state_next;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] w_count_next;
    logic                  w_sweep;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_live;
    logic                  w_flush;
    logic                  w_wr_en;
    logic                  w_set_en;
    logic                  w_rd_xzr_1;
    logic                  w_rd_xzr_2;
    logic                  w_pend_1;
    logic                  w_pend_2;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_sweep      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_sweep      = 1'b1;
                w_count_next = r_count + 1'b1;
                if (r_count == XZR) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    w_state_next = ST_CLEAR;
                    w_count_next = '0;
                end
            end
            default: w_state_next = ST_CLEAR;
        endcase
    end

    assign ready       = (r_state == ST_READY);
    assign o_dbg_state = r_state;

    // Outputs stay quiet while reset is held, even if the FSM has not left READY yet.
    assign w_live     = ready && !reset;
    assign w_flush    = w_sweep && !reset;
    assign w_rd_xzr_1 = ZERO_REG_EN && (read_reg_address_1 == XZR);
    assign w_rd_xzr_2 = ZERO_REG_EN && (read_reg_address_2 == XZR);
    assign w_wr_en    = w_live && reg_write && !(ZERO_REG_EN && (write_reg_address == XZR));
    assign w_set_en   = w_live && reserve_valid && !(ZERO_REG_EN && (reserve_address == XZR));

    assign w_mem_we    = w_flush || w_wr_en;
    assign w_mem_addr  = w_flush ? r_count : write_reg_address;
    assign w_mem_wdata = w_flush ? '0 : data;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_comb begin
        reg_out_1 = '0;
        if (w_live && !w_rd_xzr_1) begin
            if (reg_write && (write_reg_address == read_reg_address_1)) begin
                reg_out_1 = data;
            end else begin
                reg_out_1 = r_mem[read_reg_address_1];
            end
        end
    end

    always_comb begin
        reg_out_2 = '0;
        if (w_live && !w_rd_xzr_2) begin
            if (reg_write && (write_reg_address == read_reg_address_2)) begin
                reg_out_2 = data;
            end else begin
                reg_out_2 = r_mem[read_reg_address_2];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_scoreboard (
        .clk            (clk),
        .i_flush        (w_flush),
        .i_flush_idx    (r_count),
        .i_set          (w_set_en),
        .i_set_idx      (reserve_address),
        .i_clr          (w_wr_en),
        .i_clr_idx      (write_reg_address),
        .i_lookup_idx_1 (read_reg_address_1),
        .i_lookup_idx_2 (read_reg_address_2),
        .o_pending_1    (w_pend_1),
        .o_pending_2    (w_pend_2)
    );

    assign busy_1 = w_live && w_pend_1 && !w_rd_xzr_1;
    assign busy_2 = w_live && w_pend_2 && !w_rd_xzr_2;

endmodule

// File: tb/tb_legv8_param_regfile.sv
// Bench for legv8_param_regfile: directed vector table, sweep/reset sequences and
// randomized traffic checked against an array-based reference model.
module tb_legv8_param_regfile;
    import legv8_pkg::*;

    logic        clk;
    logic        reset;
    logic [4:0]  read_reg_address_1;
    logic [4:0]  read_reg_address_2;
    logic [4:0]  write_reg_address;
    logic [63:0] data;
    logic        reg_write;
    logic        reserve_valid;
    logic [4:0]  reserve_address;
    logic        clear_req;
    logic [63:0] reg_out_1;
    logic [63:0] reg_out_2;
    logic        busy_1;
    logic        busy_2;
    logic        ready;
    regfile_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    legv8_param_regfile dut (
        .clk                (clk),
        .reset              (reset),
        .read_reg_address_1 (read_reg_address_1),
        .read_reg_address_2 (read_reg_address_2),
        .write_reg_address  (write_reg_address),
        .data               (data),
        .reg_write          (reg_write),
        .reserve_valid      (reserve_valid),
        .reserve_address    (reserve_address),
        .clear_req          (clear_req),
        .reg_out_1          (reg_out_1),
        .reg_out_2          (reg_out_2),
        .busy_1             (busy_1),
        .busy_2             (busy_2),
        .ready              (ready),
        .o_dbg_state        (dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: register contents, pending flags, sweep progress
    logic [63:0] m_mem [32];
    bit          m_pend [32];
    bit          m_clearing = 1'b1;
    int          m_sweep    = 0;

    function automatic logic [63:0] m_rd(input logic [4:0] a);
        if (m_clearing || reset) return 64'd0;
        if (a == 5'd31) return 64'd0;
        if (reg_write && write_reg_address == a) return data;
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        if (m_clearing || reset) return 1'b0;
        if (a == 5'd31) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_clearing = 1'b1;
            m_sweep    = 0;
        end else if (m_clearing) begin
            m_mem[m_sweep]  = 64'd0;
            m_pend[m_sweep] = 1'b0;
            m_sweep++;
            if (m_sweep == 32) m_clearing = 1'b0;
        end else begin
            if (reg_write && write_reg_address != 5'd31) begin
                m_mem[write_reg_address]  = data;
                m_pend[write_reg_address] = 1'b0;
            end
            if (reserve_valid && reserve_address != 5'd31) m_pend[reserve_address] = 1'b1;
            if (clear_req) begin
                m_clearing = 1'b1;
                m_sweep    = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("model_rd1",   reg_out_1, m_rd(read_reg_address_1));
        chk("model_rd2",   reg_out_2, m_rd(read_reg_address_2));
        chk("model_busy1", {63'd0, busy_1}, {63'd0, m_busy(read_reg_address_1)});
        chk("model_busy2", {63'd0, busy_2}, {63'd0, m_busy(read_reg_address_2)});
        chk("model_ready", {63'd0, ready}, {63'd0, !m_clearing});
        chk("model_state", {63'd0, dbg_state}, m_clearing ? 64'(ST_CLEAR) : 64'(ST_READY));
    endtask

    // called with inputs settled one time unit after an edge
    task automatic cycle();
        #5;
        model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        reset         = 1'b0;
        reg_write     = 1'b0;
        reserve_valid = 1'b0;
        clear_req     = 1'b0;
        data          = 64'd0;
    endtask

    task automatic wait_ready(output int edges);
        edges = 0;
        while (ready !== 1'b1 && edges < 64) begin
            cycle();
            edges++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] d;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        rsv;
        logic [4:0]  rsa;
        logic [63:0] e1;
        logic [63:0] e2;
        logic        eb1;
        logic        eb2;
    } vec_t;

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [63:0] d, logic [4:0] ra1,
                                logic [4:0] ra2, logic rsv, logic [4:0] rsa, logic [63:0] e1,
                                logic [63:0] e2, logic eb1, logic eb2);
        vec_t v;
        v.we = we; v.wa = wa; v.d = d; v.ra1 = ra1; v.ra2 = ra2; v.rsv = rsv; v.rsa = rsa;
        v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
        return v;
    endfunction

    vec_t vecs[13];

    initial begin
        int edges;

        // expectations checked before the edge of each row, starting from an all-zero file
        vecs[0]  = mk(1, 9,  64'd43,    9,  4,  0, 0,  64'd43,    64'd0,     0, 0);
        vecs[1]  = mk(0, 0,  64'd0,     9,  16, 0, 0,  64'd43,    64'd0,     0, 0);
        vecs[2]  = mk(1, 16, 64'd3,     9,  16, 0, 0,  64'd43,    64'd3,     0, 0);
        vecs[3]  = mk(0, 0,  64'd0,     9,  16, 0, 0,  64'd43,    64'd3,     0, 0);
        vecs[4]  = mk(1, 5,  64'hDEAD,  5,  5,  0, 0,  64'hDEAD,  64'hDEAD,  0, 0);
        vecs[5]  = mk(1, 31, 64'hFFFF,  31, 9,  0, 0,  64'd0,     64'd43,    0, 0);
        vecs[6]  = mk(0, 0,  64'd0,     31, 31, 1, 31, 64'd0,     64'd0,     0, 0);
        vecs[7]  = mk(0, 0,  64'd0,     31, 31, 0, 0,  64'd0,     64'd0,     0, 0);
        vecs[8]  = mk(0, 0,  64'd0,     7,  7,  1, 7,  64'd0,     64'd0,     0, 0);
        vecs[9]  = mk(1, 7,  64'h77,    7,  5,  1, 7,  64'h77,    64'hDEAD,  1, 0);
        vecs[10] = mk(0, 0,  64'd0,     7,  7,  0, 0,  64'h77,    64'h77,    1, 1);
        vecs[11] = mk(1, 7,  64'h99,    7,  9,  0, 0,  64'h99,    64'd43,    1, 0);
        vecs[12] = mk(0, 0,  64'd0,     7,  7,  0, 0,  64'h99,    64'h99,    0, 0);

        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 64'd0;
            m_pend[i] = 1'b0;
        end
        idle_inputs();
        read_reg_address_1 = 5'd4;
        read_reg_address_2 = 5'd4;
        write_reg_address  = 5'd0;
        reserve_address    = 5'd0;

        // reset sequence and sweep latency
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        cycle();
        chk("ready_after_reset", {63'd0, ready}, 64'd0);
        reset = 1'b0;
        wait_ready(edges);
        chk("sweep_latency", 64'(edges), 64'd32);
        chk("reg4_port1_after_sweep", reg_out_1, 64'd0);
        chk("reg4_port2_after_sweep", reg_out_2, 64'd0);

        // directed vector table
        for (int i = 0; i < 13; i++) begin
            reg_write          = vecs[i].we;
            write_reg_address  = vecs[i].wa;
            data               = vecs[i].d;
            read_reg_address_1 = vecs[i].ra1;
            read_reg_address_2 = vecs[i].ra2;
            reserve_valid      = vecs[i].rsv;
            reserve_address    = vecs[i].rsa;
            #2;
            chk($sformatf("vec%0d_rd1", i), reg_out_1, vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), reg_out_2, vecs[i].e2);
            chk($sformatf("vec%0d_busy1", i), {63'd0, busy_1}, {63'd0, vecs[i].eb1});
            chk($sformatf("vec%0d_busy2", i), {63'd0, busy_2}, {63'd0, vecs[i].eb2});
            cycle();
        end
        idle_inputs();

        // reset in the middle of a sweep restarts it from entry 0
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("ready_mid_sweep", {63'd0, ready}, 64'd0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        wait_ready(edges);
        chk("restart_latency", 64'(edges), 64'd32);
        read_reg_address_1 = 5'd9;
        read_reg_address_2 = 5'd9;
        #1;
        chk("reg9_cleared_p1", reg_out_1, 64'd0);
        chk("reg9_cleared_p2", reg_out_2, 64'd0);

        // clear_req from READY; holding it during the sweep has no effect
        reg_write         = 1'b1;
        write_reg_address = 5'd12;
        data              = 64'h1234;
        cycle();
        reg_write = 1'b0;
        read_reg_address_1 = 5'd12;
        #1;
        chk("reg12_written", reg_out_1, 64'h1234);
        clear_req = 1'b1;
        cycle();
        chk("ready_after_clear_req", {63'd0, ready}, 64'd0);
        for (int i = 0; i < 5; i++) cycle();
        clear_req = 1'b0;
        wait_ready(edges);
        chk("clear_req_latency", 64'(1 + 5 + edges), 64'd33);
        chk("reg12_cleared", reg_out_1, 64'd0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset              = ($urandom_range(0, 299) == 0);
            clear_req          = ($urandom_range(0, 119) == 0);
            reg_write          = ($urandom_range(0, 1) == 1);
            reserve_valid      = ($urandom_range(0, 2) == 0);
            data               = {$urandom, $urandom};
            write_reg_address  = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 11));
            reserve_address    = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 11));
            read_reg_address_1 = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 11));
            read_reg_address_2 = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 11));
            cycle();
        end
        idle_inputs();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/legv8_param_regfile.md
LEGV8_PARAM_REGFILE -- requirements
Module: legv8_param_regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 64: register width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5: address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter ZERO_REG_EN, default 1: when 1, entry DEPTH-1 (XZR) reads 0 and ignores writes.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on posedge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 read_reg_address_1  in  ADDR_WIDTH  read port 1 address.
REQ-008 read_reg_address_2  in  ADDR_WIDTH  read port 2 address.
REQ-009 write_reg_address  in  ADDR_WIDTH  write address.
REQ-010 data  in  DATA_WIDTH  write data.
REQ-011 reg_write  in  1  write enable.
REQ-012 reserve_valid  in  1  mark reserve_address pending (in-flight producer).
REQ-013 reserve_address  in  ADDR_WIDTH  register to mark pending.
REQ-014 clear_req  in  1  request full clear sweep.
REQ-015 reg_out_1 / reg_out_2  out  DATA_WIDTH  read data, ports 1/2.
REQ-016 busy_1 / busy_2  out  1  pending bit of the read_reg_address_1 / read_reg_address_2 entry.
REQ-017 ready  out  1  high in READY state only.

Function
REQ-018 FSM states CLEAR and READY; reset forces CLEAR with sweep counter 0.
REQ-019 In CLEAR each posedge with reset=0 SHALL write 0 to entry[counter] and its pending bit, then increment counter.
REQ-020 The posedge clearing entry DEPTH-1 SHALL move to READY; ready rises exactly DEPTH edges after reset deasserts (32 at default).
REQ-021 clear_req sampled high in READY SHALL enter CLEAR with counter 0; clear_req in CLEAR is ignored.
REQ-022 Reset asserted mid-sweep SHALL restart the sweep at counter 0.
REQ-023 In CLEAR: reg_write and reserve_valid ignored; reg_out_* = 0; busy_* = 0.
REQ-024 Reads are combinational (zero latency).
REQ-025 Read of XZR with ZERO_REG_EN=1 SHALL return 0 regardless of writes.
REQ-026 Write-through: in READY, if reg_write=1 and write_reg_address equals a read address (not XZR), that port SHALL return data the same cycle.
REQ-027 In READY, reg_write=1 SHALL store data into entry[write_reg_address] at posedge (not XZR when ZERO_REG_EN=1).
REQ-028 A completed write SHALL clear that entry's pending bit; reserve_valid SHALL set pending bit of reserve_address at posedge.
REQ-029 Same-edge reserve and write to the same address: the set wins, and pending stays 1.
REQ-030 XZR pending bit is always 0 when ZERO_REG_EN=1.
REQ-031 busy_* are combinational from pending bits; no bypass of same-cycle reserve.
REQ-032 Both read ports may address the same entry; results SHALL be identical.

Reset
REQ-033 Reset SHALL synchronously set state=CLEAR, counter=0, ready=0; array contents are zeroed by the sweep, not in parallel.
REQ-034 During and after reset until ready=1: reg_out_*=0, busy_*=0.

Structure
REQ-035 Package legv8_pkg SHALL hold default DATA_WIDTH/ADDR_WIDTH, XZR index and the CLEAR/READY state encoding.
REQ-036 Pending-bit logic SHALL be a sub-module regfile_scoreboard (DEPTH bits, set/clear/flush ports, two lookup ports).

Verification
REQ-037 Reset 1 cycle, release -> ready=0 for 31 edges, ready=1 after the 32nd; reg 4 read on both ports = 0.
REQ-038 Write 43 to reg 9, next cycle read port 1 reg 9 -> 43; then write 3 to reg 16, read port 2 reg 16 -> 3 while port 1 still 43.
REQ-039 reg_write=1, reg 5, data 0xDEAD, read port 1 reg 5 same cycle -> 0xDEAD before the edge (bypass).
REQ-040 Write 0xFFFF to reg 31 -> read reg 31 = 0; reserve reg 31 -> busy=0.
REQ-041 Reserve reg 7 -> busy_1=1 on next cycle; same-edge reserve+write reg 7 -> busy stays 1; later write alone -> busy=0, value visible.
REQ-042 Write 43 to reg 9, assert reset at sweep count 10, release -> 32 more edges to ready; reg 9 reads 0.
